alu593_sched: RTL and testbench

- Shares one ALU593 datapath among NUM_REQ requesters.
- Round-robin arbitration picks one requester at a time.
- For the winner: drives the ALU's A/B/op/start, waits for done, captures the 16-bit result and returns it to that requester.
- Handles the ALU's no_op case, which has no done handshake.
- Recovers from a hung ALU with a done timeout.
- Sits between client blocks and the ALU593 instance.

---
 rtl/alu593_pkg.sv | 32 +++
 rtl/alu593_sched_rr_arbiter.sv | 39 +++
 rtl/alu593_sched.sv | 160 ++++++++++++++++
 tb/tb_alu593_sched.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu593_pkg.sv
// Shared ALU593 types: operation encoding, datapath widths and scheduler states.
// Also holds the round-robin pointer advance used by the scheduler.
package alu593_pkg;

  localparam int ALU_OPND_W = 8;
  localparam int ALU_RES_W  = 16;
  localparam int ALU_OP_W   = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    no_op  = 4'h0,
    op_add = 4'h1,
    op_sub = 4'h2,
    op_mul = 4'h3,
    op_and = 4'h4,
    op_or  = 4'h5,
    op_xor = 4'h6,
    op_shl = 4'h7,
    op_shr = 4'h8
  } operation_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } sched_state_t;

  // Pointer moves to the requester just after the one granted, wrapping at n.
  function automatic int rr_next(input int g, input int n);
    return (g + 1 >= n) ? 0 : g + 1;
  endfunction

endpackage

// File: rtl/alu593_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, ascending
// with wrap; returns a one-hot grant, its encoded index and an any-grant flag.
module alu593_sched_rr_arbiter #(
  parameter  int NUM_REQ = 2,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_vld
);

  logic [IDX_W-1:0] cand;
  int               pos;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    cand      = ptr;
    pos       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = int'(ptr) + k;
      if (pos >= NUM_REQ) begin
        pos = pos - NUM_REQ;
      end
      cand = IDX_W'(pos);
      if (!grant_vld && req[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
    if (grant_vld) begin
      grant = NUM_REQ'(1) << grant_idx;
    end
  end

endmodule

// File: rtl/alu593_sched.sv
// Shares one ALU593 among NUM_REQ requesters: round-robin accept, registered
// ALU drive with a done timeout, and a one-cycle response back to the winner.
module alu593_sched
  import alu593_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*ALU_OPND_W-1:0]  req_a,
  input  logic [NUM_REQ*ALU_OPND_W-1:0]  req_b,
  input  logic [NUM_REQ*ALU_OP_W-1:0]    req_op,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [ALU_RES_W-1:0]           rsp_result,
  output logic                           rsp_timeout,
  output logic [ALU_OPND_W-1:0]          alu_a,
  output logic [ALU_OPND_W-1:0]          alu_b,
  output logic [ALU_OP_W-1:0]            alu_op,
  output logic                           alu_start,
  input  logic                           alu_done,
  input  logic [ALU_RES_W-1:0]           alu_result
);

  localparam int               IDX_W    = $clog2(NUM_REQ);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  sched_state_t          state;
  sched_state_t          state_nxt;
  logic [IDX_W-1:0]      ptr;
  logic [IDX_W-1:0]      grant_idx;
  logic [IDX_W-1:0]      lat_idx;
  logic [NUM_REQ-1:0]    grant;
  logic                  grant_vld;
  logic [CNT_W-1:0]      cnt;
  operation_t            lat_op;
  logic [ALU_OPND_W-1:0] sel_a;
  logic [ALU_OPND_W-1:0] sel_b;
  logic [ALU_OP_W-1:0]   sel_op;
  logic                  accept;
  logic                  done_hit;
  logic                  tmo_hit;
  logic                  leave_issue;

  alu593_sched_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req       (req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  // Ready is only offered from IDLE and is held low while reset is asserted.
  assign req_ready = (state == IDLE && reset_n) ? grant : '0;

  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        sel_a  = req_a[i*ALU_OPND_W +: ALU_OPND_W];
        sel_b  = req_b[i*ALU_OPND_W +: ALU_OPND_W];
        sel_op = req_op[i*ALU_OP_W +: ALU_OP_W];
      end
    end
  end

  // A done seen on the final timeout cycle still wins over the timeout.
  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    done_hit    = 1'b0;
    tmo_hit     = 1'b0;
    leave_issue = 1'b0;
    case (state)
      IDLE: begin
        if (grant_vld) begin
          accept    = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (lat_op == no_op) begin
          leave_issue = 1'b1;
        end else if (alu_done) begin
          done_hit    = 1'b1;
          leave_issue = 1'b1;
        end else if (cnt == CNT_LAST) begin
          tmo_hit     = 1'b1;
          leave_issue = 1'b1;
        end
        if (leave_issue) begin
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      ptr         <= '0;
      cnt         <= '0;
      lat_idx     <= '0;
      lat_op      <= no_op;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_op      <= '0;
      alu_start   <= 1'b0;
      rsp_valid   <= '0;
      rsp_result  <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      rsp_valid   <= '0;
      rsp_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            lat_idx   <= grant_idx;
            lat_op    <= operation_t'(sel_op);
            alu_a     <= sel_a;
            alu_b     <= sel_b;
            alu_op    <= sel_op;
            alu_start <= 1'b1;
            cnt       <= '0;
            ptr       <= IDX_W'(rr_next(int'(grant_idx), NUM_REQ));
          end
        end
        ISSUE: begin
          if (leave_issue) begin
            alu_start   <= 1'b0;
            cnt         <= '0;
            rsp_valid   <= NUM_REQ'(1) << lat_idx;
            rsp_result  <= done_hit ? alu_result : '0;
            rsp_timeout <= tmo_hit;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RESP: begin
          alu_start <= 1'b0;
          cnt       <= '0;
        end
        default: begin
          alu_start <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu593_sched.sv
// Scoreboard bench for alu593_sched: a transaction-level model predicts grants,
// ALU drive windows and responses; a separate monitor checks every response.
module tb_alu593_sched;
  import alu593_pkg::*;

  localparam int N   = 3;
  localparam int TMO = 64;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*8-1:0]   req_a;
  logic [N*8-1:0]   req_b;
  logic [N*4-1:0]   req_op;
  logic [N-1:0]     rsp_valid;
  logic [15:0]      rsp_result;
  logic             rsp_timeout;
  logic [7:0]       alu_a;
  logic [7:0]       alu_b;
  logic [3:0]       alu_op;
  logic             alu_start;
  logic             alu_done;
  logic [15:0]      alu_result;

  alu593_sched #(
    .NUM_REQ (N),
    .TIMEOUT (TMO)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_op      (req_op),
    .rsp_valid   (rsp_valid),
    .rsp_result  (rsp_result),
    .rsp_timeout (rsp_timeout),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op      (alu_op),
    .alu_start   (alu_start),
    .alu_done    (alu_done),
    .alu_result  (alu_result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [3:0]  op;
    int          delay;
    logic [15:0] res;
  } req_t;

  typedef struct {
    int          idx;
    logic [15:0] res;
    logic        tmo;
    int          cyc;
  } exp_t;

  req_t slot [N];
  bit   pend [N];
  req_t cur;
  exp_t sbq [$];
  exp_t mon_e;
  int   mptr     = 0;
  int   issue_lo = 1;
  int   issue_hi = 0;
  int   rsp_cyc  = -1;
  int   cyc      = 0;
  int   icnt     = 0;
  int   checks   = 0;
  int   errors   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic post(input int i, input logic [3:0] op, input logic [7:0] a,
                      input logic [7:0] b, input int delay, input logic [15:0] res);
    slot[i].a     = a;
    slot[i].b     = b;
    slot[i].op    = op;
    slot[i].delay = delay;
    slot[i].res   = res;
    pend[i]       = 1'b1;
  endtask

  task automatic rand_post(input int i);
    int r;
    int d;
    r = $urandom_range(0, 19);
    if (r < 14)      d = $urandom_range(0, 4);
    else if (r < 16) d = TMO - 1;
    else if (r < 18) d = 1000;
    else             d = $urandom_range(5, 20);
    post(i, 4'($urandom_range(0, 8)), 8'($urandom), 8'($urandom), d, 16'($urandom));
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]     = pend[i];
      req_a[i*8 +: 8]  = slot[i].a;
      req_b[i*8 +: 8]  = slot[i].b;
      req_op[i*4 +: 4] = slot[i].op;
    end
  endtask

  function automatic int winner();
    for (int k = 0; k < N; k++) begin
      int j = (mptr + k) % N;
      if (pend[j]) return j;
    end
    return -1;
  endfunction

  function automatic bit any_pend();
    for (int i = 0; i < N; i++) if (pend[i]) return 1'b1;
    return 1'b0;
  endfunction

  // One clock of the reference model: predict ALU drive and ready, then accept.
  task automatic step();
    int       w;
    int       k;
    bit       exp_start;
    logic [N-1:0] exp_ready;
    exp_t     e;
    drive();
    @(negedge clk);
    exp_start = (cyc >= issue_lo) && (cyc <= issue_hi);
    chk("alu_start", 32'(alu_start), 32'(exp_start));
    if (exp_start) begin
      chk("alu_a", 32'(alu_a), 32'(cur.a));
      chk("alu_b", 32'(alu_b), 32'(cur.b));
      chk("alu_op", 32'(alu_op), 32'(cur.op));
    end
    w = (cyc > rsp_cyc) ? winner() : -1;
    exp_ready = '0;
    if (w >= 0) exp_ready[w] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    if (w >= 0) begin
      cur = slot[w];
      if (cur.op == no_op) begin
        k = 0; e.res = 16'h0000; e.tmo = 1'b0;
      end else if (cur.delay < TMO) begin
        k = cur.delay; e.res = cur.res; e.tmo = 1'b0;
      end else begin
        k = TMO - 1; e.res = 16'h0000; e.tmo = 1'b1;
      end
      issue_lo = cyc + 1;
      issue_hi = cyc + 1 + k;
      rsp_cyc  = cyc + 2 + k;
      e.idx    = w;
      e.cyc    = rsp_cyc;
      sbq.push_back(e);
      mptr = (w + 1) % N;
    end
    @(posedge clk);
    #1;
    if (w >= 0) pend[w] = 1'b0;
    drive();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((any_pend() || sbq.size() != 0 || cyc <= rsp_cyc) && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL drain_bound: still busy after %0d cycles, required idle", n);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #2;
    chk("rst_alu_start", 32'(alu_start), 32'h0);
    chk("rst_alu_a", 32'(alu_a), 32'h0);
    chk("rst_alu_b", 32'(alu_b), 32'h0);
    chk("rst_alu_op", 32'(alu_op), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_result", 32'(rsp_result), 32'h0);
    chk("rst_rsp_timeout", 32'(rsp_timeout), 32'h0);
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    sbq.delete();
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    mptr     = 0;
    issue_lo = 1;
    issue_hi = 0;
    rsp_cyc  = -1;
    drive();
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // ALU stand-in: done on the planned ISSUE cycle, random noise elsewhere.
  initial begin
    alu_done   = 1'b0;
    alu_result = 16'h0;
    forever begin
      @(negedge clk);
      if (alu_start === 1'b1) begin
        alu_done   = (icnt == cur.delay);
        alu_result = (icnt == cur.delay) ? cur.res : 16'($urandom);
        icnt++;
      end else begin
        icnt       = 0;
        alu_done   = ($urandom_range(0, 3) == 0);
        alu_result = 16'($urandom);
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (rsp_valid != '0 || (sbq.size() > 0 && sbq[0].cyc == cyc)) begin
        if (sbq.size() == 0) begin
          chk("rsp_unexpected", 32'(rsp_valid), 32'h0);
        end else begin
          mon_e = sbq.pop_front();
          chk("rsp_cycle", 32'(cyc), 32'(mon_e.cyc));
          chk("rsp_valid", 32'(rsp_valid), 32'(1) << mon_e.idx);
          chk("rsp_result", 32'(rsp_result), 32'(mon_e.res));
          chk("rsp_timeout", 32'(rsp_timeout), 32'(mon_e.tmo));
        end
      end else begin
        chk("rsp_timeout_idle", 32'(rsp_timeout), 32'h0);
      end
    end
  end

  initial begin
    reset_n   = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0;
      slot[i] = '{a: 8'h0, b: 8'h0, op: 4'h0, delay: 0, res: 16'h0};
    end
    cur = slot[0];
    #1;
    do_reset();

    // Contention straight out of reset, then both held valid continuously.
    post(0, op_add, 8'h01, 8'h00, 1, 16'h0001);
    post(1, op_sub, 8'h05, 8'h03, 2, 16'h0002);
    drain(100);
    for (int s = 0; s < 24; s++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pend[i]) post(i, op_add, 8'($urandom), 8'($urandom), $urandom_range(0, 2), 16'($urandom));
      end
      step();
    end
    drain(100);

    // Single add with done on the third ISSUE cycle.
    post(0, op_add, 8'h12, 8'h34, 2, 16'h0046);
    drain(100);

    // no_op from requester 1.
    post(1, no_op, 8'hAA, 8'h55, 0, 16'hFFFF);
    drain(100);

    // Hung ALU, then a normal request.
    post(0, op_add, 8'h01, 8'h01, 1000, 16'h1234);
    drain(200);
    post(1, op_xor, 8'hF0, 8'h0F, 0, 16'h5555);
    drain(100);

    // Done on the very last ISSUE cycle.
    post(2, op_mul, 8'h10, 8'h20, TMO - 1, 16'hBEEF);
    drain(200);

    for (int s = 0; s < 400; s++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 3) == 0) rand_post(i);
      end
      step();
    end
    drain(400);

    // Reset while an op is in ISSUE with another requester waiting.
    post(0, op_add, 8'h01, 8'h02, 1000, 16'h7777);
    repeat (4) step();
    post(2, op_or, 8'h0C, 8'h03, 0, 16'h000F);
    repeat (3) step();
    do_reset();
    post(0, op_add, 8'h03, 8'h04, 0, 16'h0001);
    post(1, op_add, 8'h05, 8'h06, 0, 16'h0002);
    drain(100);
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit: simulation did not finish, required completion");
    $fatal(1, "time limit");
  end

endmodule
